mandel_pixel_engine: RTL

//  Per-pixel Mandelbrot iteration engine, directly downstream of the 15-bit raster pixel counter.

---
 rtl/mandel_pixel_engine.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/mandel_pixel_engine.sv
// mandel_pixel_engine
//   Per-pixel Mandelbrot iteration engine. It maps the raster counter's pixel
//   index to a complex point c and iterates z <- z^2 + c at one iteration per
//   clock. It stops when |z| > 2 or when MAX_ITER is reached. Each result goes
//   out over a valid/ready handshake. After the result is accepted, the engine
//   pulses pix_adv to step the counter, then waits out the counter's 2-cycle
//   update latency before loading the next pixel.
//
//   All z and c values are signed Q4.FRAC, 16 bits wide.
//
// Ports
//   clk, rst     clock; synchronous active-high reset
//   start        one-cycle pulse in IDLE that begins a frame
//   pix_idx      current pixel index from the raster counter
//   pix_adv      one-cycle pulse, drives the counter's enable
//   out_valid    result valid
//   out_ready    consumer accepts the result
//   out_idx      pixel index of the result
//   out_iter     iteration count at escape, or MAX_ITER
//   out_inset    1 = did not escape within MAX_ITER
//   busy         high in every state except IDLE
//   frame_done   one-cycle pulse after pixel 0x7FFF is accepted
//   frame_iters  (MANDEL_PERF_EN only) saturating sum of accepted out_iter
//
// Build option
//   MANDEL_PERF_EN : adds the frame_iters performance counter port.

module mandel_pixel_engine #(
  parameter int IMG_W_LOG2 = 8,
  parameter int IMG_H_LOG2 = 7,
  parameter int FRAC       = 12,
  parameter int RE_MIN     = -8192,
  parameter int IM_MAX     = 4096,
  parameter int STEP       = 64,
  parameter int MAX_ITER   = 255,
  parameter int ITER_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [14:0]       pix_idx,
  output logic              pix_adv,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [14:0]       out_idx,
  output logic [ITER_W-1:0] out_iter,
  output logic              out_inset,
  output logic              busy,
  output logic              frame_done
`ifdef MANDEL_PERF_EN
  ,
  output logic [31:0]       frame_iters
`endif
);

  typedef enum logic [2:0] {IDLE, LOAD, ITER, DONE, ADV, SETTLE} state_t;

  // Escape threshold 4.0 expressed in Q8.2FRAC.
  localparam logic signed [32:0] ESC = 33'sd1 <<< (2 * FRAC + 2);

  state_t             state;
  logic        [14:0] idx;
  logic signed [15:0] zr, zi, c_re, c_im;
  logic [ITER_W-1:0]  iter;
  logic               settle_cnt;

  logic        [15:0] x_ext, y_ext;
  logic signed [31:0] rr, ii, ri;
  logic signed [32:0] mag2;
  logic               escape;

  always_comb begin
    x_ext  = 16'(pix_idx[IMG_W_LOG2-1:0]);
    y_ext  = 16'(pix_idx[IMG_W_LOG2+IMG_H_LOG2-1:IMG_W_LOG2]);
    rr     = zr * zr;
    ii     = zi * zi;
    ri     = zr * zi;
    mag2   = {rr[31], rr} + {ii[31], ii};
    escape = (mag2 > ESC);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= '0;
      zr         <= '0;
      zi         <= '0;
      c_re       <= '0;
      c_im       <= '0;
      iter       <= '0;
      settle_cnt <= 1'b0;
      pix_adv    <= 1'b0;
      out_valid  <= 1'b0;
      out_idx    <= '0;
      out_iter   <= '0;
      out_inset  <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      pix_adv    <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= LOAD;
            busy  <= 1'b1;
          end
        end
        LOAD: begin
          idx   <= pix_idx;
          c_re  <= 16'(RE_MIN) + x_ext * 16'(STEP);
          c_im  <= 16'(IM_MAX) - y_ext * 16'(STEP);
          zr    <= '0;
          zi    <= '0;
          iter  <= '0;
          state <= ITER;
        end
        ITER: begin
          if (escape || (iter == ITER_W'(MAX_ITER))) begin
            state     <= DONE;
            out_valid <= 1'b1;
            out_idx   <= idx;
            out_iter  <= iter;
            out_inset <= ~escape;
          end else begin
            // Shifted products are truncated to 16 bits before adding c;
            // the sum wraps modulo 2^16 either way.
            zr   <= 16'((rr - ii) >>> FRAC) + c_re;
            zi   <= 16'((ri <<< 1) >>> FRAC) + c_im;
            iter <= iter + ITER_W'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (idx == 15'h7FFF) begin
              state      <= IDLE;
              busy       <= 1'b0;
              frame_done <= 1'b1;
            end else begin
              state   <= ADV;
              pix_adv <= 1'b1;
            end
          end
        end
        ADV: begin
          settle_cnt <= 1'b0;
          state      <= SETTLE;
        end
        SETTLE: begin
          if (settle_cnt) state <= LOAD;
          settle_cnt <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MANDEL_PERF_EN
  logic [32:0] iter_sum;

  always_comb iter_sum = {1'b0, frame_iters} + 33'(out_iter);

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_iters <= '0;
    end else if (state == IDLE && start) begin
      frame_iters <= '0;
    end else if (state == DONE && out_ready) begin
      frame_iters <= iter_sum[32] ? '1 : iter_sum[31:0];
    end
  end
`endif

endmodule
